// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//
// Four requesters share a bank of four N-bit registers. A two-state FSM
// (IDLE/WRITE) picks one requester per arbitration using round-robin,
// grants it for exactly one WRITE cycle, and stores its data into the bank
// register it addresses. If the granted requester withdraws its request
// during WRITE, the write is dropped and a sticky error flag is raised.
//
// Ports
//   clk       in   system clock, rising-edge
//   reset     in   asynchronous, active-high reset
//   req       in   [3:0]    per-requester write request
//   req_addr  in   [7:0]    requester i target register in bits [2i+1:2i]
//   req_data  in   [4N-1:0] requester i write data in bits [N*i+N-1:N*i]
//   gnt       out  [3:0]    one-hot grant, high during the winner's WRITE
//   busy      out           high while the FSM is in WRITE
//   bank_out  out  [4N-1:0] bank register j on bits [N*j+N-1:N*j]
//   wr_count  out  [7:0]    completed writes, saturating at 255
//   err       out           sticky: granted requester dropped req in WRITE
// ---------------------------------------------------------------------------
module reg_bank_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [7:0]     req_addr,
  input  logic [4*N-1:0] req_data,
  output logic [3:0]     gnt,
  output logic           busy,
  output logic [4*N-1:0] bank_out,
  output logic [7:0]     wr_count,
  output logic           err
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   winner_q, winner_d;
  logic [N-1:0] bank_q [4];
  logic [7:0]   wr_count_q;
  logic         err_q;

  logic [3:0]   bank_en;
  logic         wr_inc;
  logic         err_set;
  logic [1:0]   pick;
  logic [1:0]   probe;
  logic [1:0]   wr_addr;
  logic [N-1:0] wr_data;

  // Round-robin pick: walk offsets from 3 down to 0 so the requester closest
  // to ptr (smallest offset) overwrites any farther one and wins.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick  = ptr_q;
    probe = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      probe = ptr_q + 2'(k);
      if (req[probe]) pick = probe;
    end
  end

  // Address and data of the registered winner, used only in WRITE.
  assign wr_addr = req_addr[{winner_q, 1'b0} +: 2];
  assign wr_data = req_data[N*winner_q +: N];

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    gnt      = '0;
    busy     = 1'b0;
    bank_en  = '0;
    wr_inc   = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          winner_d = pick;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        gnt[winner_q] = 1'b1;
        busy          = 1'b1;
        state_d       = IDLE;
        // The pointer advances past the winner even when the write is dropped.
        ptr_d         = winner_q + 2'd1;
        if (req[winner_q]) begin
          bank_en[wr_addr] = 1'b1;
          wr_inc           = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
    end
  end

  // NOTE: the bank is only four registers and must read as zero right after
  // reset, so it is reset like ordinary flops rather than treated as a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) bank_q[j] <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (bank_en[j]) bank_q[j] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wr_inc && (wr_count_q != 8'hFF)) wr_count_q <= wr_count_q + 8'd1;
      if (err_set) err_q <= 1'b1;
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_bank_out
    assign bank_out[N*j +: N] = bank_q[j];
  end

  assign wr_count = wr_count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//
// Directed bench for reg_bank_arbiter (N = 8). Inputs change 1 ns after a
// rising edge and outputs are sampled there too, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

  localparam int N = 8;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [7:0]     req_addr;
  logic [4*N-1:0] req_data;
  logic [3:0]     gnt;
  logic           busy;
  logic [4*N-1:0] bank_out;
  logic [7:0]     wr_count;
  logic           err;

  int n_checks = 0;
  int n_bad    = 0;

  reg_bank_arbiter #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .bank_out (bank_out),
    .wr_count (wr_count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    #2;
    n_checks++;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (bank_out !== 32'h0) begin n_bad++; $display("FAIL reset_bank: got %h want 00000000", bank_out); end
    n_checks++;
    if (wr_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", wr_count); end
    n_checks++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    req_addr = 8'h02;
    req_data = 32'h000000A5;
    req      = 4'b0001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_gnt: got gnt=%b busy=%b want 0001/1", gnt, busy);
    end
    tick();
    req = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_drop: got %b want 0000", gnt); end
    n_checks++;
    if (bank_out !== 32'h00A50000) begin n_bad++; $display("FAIL single_bank: got %h want 00a50000", bank_out); end
    n_checks++;
    if (wr_count !== 8'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", wr_count); end
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic found;
    do_reset();
    req_addr = 8'hE4;
    req_data = 32'h13121110;
    req      = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        tick();
        if (gnt !== 4'b0000) found = 1'b1;
      end
      n_checks++;
      if (!found || gnt !== (4'b0001 << k)) begin
        n_bad++; $display("FAIL rr_order_%0d: got %b want %b", k, gnt, 4'b0001 << k);
      end
      tick();
      req[k] = 1'b0;
    end
    n_checks++;
    if (bank_out !== 32'h13121110) begin n_bad++; $display("FAIL rr_bank: got %h want 13121110", bank_out); end
    n_checks++;
    if (wr_count !== 8'd4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", wr_count); end
    n_checks++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err: got %b want 0", err); end
  endtask

  task automatic test_violation();
    req_data = 32'h00990000;
    req      = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0100) begin n_bad++; $display("FAIL viol_gnt: got %b want 0100", gnt); end
    req = 4'b0000;
    tick();
    n_checks++;
    if (bank_out !== 32'h13121110) begin n_bad++; $display("FAIL viol_bank: got %h want 13121110", bank_out); end
    n_checks++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL viol_err: got %b want 1", err); end
    n_checks++;
    if (wr_count !== 8'd4) begin n_bad++; $display("FAIL viol_count: got %0d want 4", wr_count); end
    tick();
    n_checks++;
    if (err !== 1'b1 || gnt !== 4'b0000) begin
      n_bad++; $display("FAIL viol_sticky: got err=%b gnt=%b want 1/0000", err, gnt);
    end
  endtask

  // ptr is 3 after the violation, so requester 3 must win first.
  task automatic test_fairness_wrap();
    logic [3:0] exp_gnt [8];
    exp_gnt = '{4'b1000, 4'b0000, 4'b0001, 4'b0000,
                4'b1000, 4'b0000, 4'b0001, 4'b0000};
    req_addr = 8'h41;
    req_data = 32'h33000044;
    req      = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_gnt[c] || busy !== (exp_gnt[c] != 4'b0000)) begin
        n_bad++; $display("FAIL wrap_cycle_%0d: got gnt=%b busy=%b want %b", c, gnt, busy, exp_gnt[c]);
      end
    end
    req = 4'b0000;
    n_checks++;
    if (bank_out !== 32'h13124410) begin n_bad++; $display("FAIL wrap_bank: got %h want 13124410", bank_out); end
    n_checks++;
    if (wr_count !== 8'd8) begin n_bad++; $display("FAIL wrap_count: got %0d want 8", wr_count); end
    n_checks++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL wrap_err: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_write();
    req_addr = 8'h00;
    req_data = 32'h000000FF;
    req      = 4'b0001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_pre_gnt: got %b want 0001", gnt); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_gnt: got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    n_checks++;
    if (bank_out !== 32'h0) begin n_bad++; $display("FAIL midrst_bank: got %h want 00000000", bank_out); end
    n_checks++;
    if (wr_count !== 8'd0 || err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_count_err: got count=%0d err=%b want 0/0", wr_count, err);
    end
    tick();
    tick();
    req   = 4'b0000;
    reset = 1'b0;
    n_checks++;
    if (bank_out !== 32'h0) begin n_bad++; $display("FAIL midrst_bank_after: got %h want 00000000", bank_out); end
    // Arbitration restarts from ptr 0: with req 0011 requester 0 must win.
    req_addr = 8'h03;
    req_data = 32'h0000005A;
    req      = 4'b0011;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr0: got %b want 0001", gnt); end
    tick();
    req = 4'b0000;
    n_checks++;
    if (bank_out !== 32'h5A000000 || wr_count !== 8'd1) begin
      n_bad++; $display("FAIL midrst_first_write: got bank=%h count=%0d want 5a000000/1", bank_out, wr_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req_addr = 8'h01;
    req_data = 32'h00000077;
    req      = 4'b0001;
    for (int c = 0; c < 508; c++) tick();
    n_checks++;
    if (wr_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", wr_count); end
    tick();
    tick();
    n_checks++;
    if (wr_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", wr_count); end
    for (int c = 0; c < 10; c++) tick();
    req = 4'b0000;
    n_checks++;
    if (wr_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", wr_count); end
    n_checks++;
    if (bank_out !== 32'h00007700 || err !== 1'b0) begin
      n_bad++; $display("FAIL sat_bank: got bank=%h err=%b want 00007700/0", bank_out, err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_violation();
    test_fairness_wrap();
    test_reset_mid_write();
    test_saturation();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
